// File: rtl/vliw_pkg.sv
// Shared VLIW bundle definitions for the fetch slice: lane count, NOP encoding,
// bundle/lane-PC types and small address helpers.
package vliw_pkg;

    localparam int unsigned LANES    = 4;
    localparam int unsigned BUNDLE_W = 32 * LANES;
    localparam int unsigned ALIGN    = $clog2(4 * LANES);

    localparam logic [31:0] NOP_INST   = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK = 32'(4 * LANES - 1);
    localparam logic [31:0] BUNDLE_INC = 32'(4 * LANES);

    typedef logic [BUNDLE_W-1:0]   bundle_t;
    typedef logic [LANES-1:0][31:0] lane_pc_t;

    localparam bundle_t NOP_BUNDLE = {LANES{NOP_INST}};

    // Clear the low ALIGN bits so the address points at a bundle boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ~ALIGN_MASK;
    endfunction

    // Expand a bundle PC into one PC per lane, lane i at base + 4*i.
    function automatic lane_pc_t lane_pcs(input logic [31:0] base);
        lane_pc_t l;
        for (int unsigned i = 0; i < LANES; i++) begin
            l[i] = base + 32'(4 * i);
        end
        return l;
    endfunction

endpackage

// File: rtl/branch_fetch_fifo.sv
// First-word-fall-through FIFO with registered storage and a synchronous flush.
// The head entry is visible combinationally whenever count is non-zero.
module branch_fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pop only real entries; a push into a full FIFO is allowed when a pop frees a slot.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count < CW'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy update; flush empties the FIFO and discards any push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/branch_fetch.sv
// Fetch stage: owns the bundle PC, issues credit-limited in-order requests to
// instruction memory, buffers returned bundles and presents one per cycle.
// A redirect from branch execute retargets the PC and squashes younger work.
module branch_fetch
    import vliw_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         new_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [31:0]         imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [BUNDLE_W-1:0] imem_rsp_data,
    output logic                inst_valid,
    output logic [BUNDLE_W-1:0] inst,
    output logic [BUNDLE_W-1:0] inst_pc
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    // Epoch is wide enough that the current value never equals the tag of any
    // request still in flight, even after back-to-back redirects.
    localparam int unsigned EW = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [EW-1:0] epoch;
        logic [31:0]   addr;
    } tag_t;

    typedef struct packed {
        bundle_t     data;
        logic [31:0] addr;
    } entry_t;

    logic [31:0]   pc;
    logic [EW-1:0] epoch;
    logic          epoch_used;

    tag_t          tag_in;
    tag_t          tag_head;
    logic [CW-1:0] outstanding;

    entry_t        buf_in;
    entry_t        buf_head;
    logic [CW-1:0] buf_count;

    logic [CW:0]   credit_sum;
    logic          req_fire;
    logic          rsp_keep;
    logic          buf_pop;
    logic [31:0]   bundle_pc;

    // Credit, request handshake, response filtering and pop decision.
    always_comb begin
        credit_sum     = {1'b0, outstanding} + {1'b0, buf_count};
        imem_req_valid = rst && !branch_taken && (credit_sum < (CW + 1)'(BUF_DEPTH));
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_keep       = imem_rsp_valid && (tag_head.epoch == epoch);
        buf_pop        = inst_valid && !stall;
        tag_in         = '{epoch: epoch, addr: pc};
        buf_in         = '{data: imem_rsp_data, addr: tag_head.addr};
    end

    // PC and epoch tracking; a redirect only advances the epoch if the current
    // epoch has issued at least one request, so repeated redirects stay distinct.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= align_pc(RESET_PC);
            epoch      <= '0;
            epoch_used <= 1'b0;
        end else if (branch_taken) begin
            pc <= align_pc(new_pc);
            if (epoch_used) begin
                epoch      <= epoch + EW'(1);
                epoch_used <= 1'b0;
            end
        end else if (req_fire) begin
            pc         <= pc + BUNDLE_INC;
            epoch_used <= 1'b1;
        end
    end

    branch_fetch_fifo #(
        .WIDTH($bits(tag_t)),
        .DEPTH(BUF_DEPTH)
    ) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (req_fire),
        .push_data(tag_in),
        .pop      (imem_rsp_valid),
        .head     (tag_head),
        .count    (outstanding)
    );

    branch_fetch_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(BUF_DEPTH)
    ) u_bundle_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (branch_taken),
        .push     (rsp_keep),
        .push_data(buf_in),
        .pop      (buf_pop),
        .head     (buf_head),
        .count    (buf_count)
    );

    // Presented bundle: head of the buffer, or NOPs at the next fetch PC when empty.
    always_comb begin
        inst_valid = (buf_count != '0);
        inst       = inst_valid ? buf_head.data : NOP_BUNDLE;
        bundle_pc  = inst_valid ? buf_head.addr : pc;
        inst_pc    = lane_pcs(bundle_pc);
    end

endmodule

// File: tb/tb_branch_fetch.sv
// Self-checking bench for branch_fetch: the bench plays instruction memory with
// random in-order latency and keeps a queue-based reference of in-flight
// requests (with a live/squashed flag) and of buffered bundles.
module tb_branch_fetch;
    import vliw_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                stall = 1'b0;
    logic                branch_taken = 1'b0;
    logic [31:0]         new_pc = '0;
    logic                imem_req_valid;
    logic                imem_req_ready = 1'b0;
    logic [31:0]         imem_req_addr;
    logic                imem_rsp_valid = 1'b0;
    logic [BUNDLE_W-1:0] imem_rsp_data = '0;
    logic                inst_valid;
    logic [BUNDLE_W-1:0] inst;
    logic [BUNDLE_W-1:0] inst_pc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } req_t;

    req_t        pend[$];
    logic [31:0] mbuf[$];
    logic [31:0] exp_pc;

    branch_fetch #(
        .RESET_PC (RST_PC),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .new_pc        (new_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [BUNDLE_W-1:0] mem_data(input logic [31:0] addr);
        logic [BUNDLE_W-1:0] d;
        for (int i = 0; i < LANES; i++) begin
            d[32*i +: 32] = (addr ^ 32'hC0DE_0000) + 32'(i * 7 + 1);
        end
        return d;
    endfunction

    function automatic logic [BUNDLE_W-1:0] exp_lanes(input logic [31:0] base);
        logic [BUNDLE_W-1:0] l;
        for (int i = 0; i < LANES; i++) begin
            l[32*i +: 32] = base + 32'(4 * i);
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [BUNDLE_W-1:0] obs, input logic [BUNDLE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check mid-cycle, then advance the model
    // to what the coming posedge must produce.
    task automatic cycle(input logic s, input logic bt, input logic [31:0] npc,
                         input logic rdy, input int lat_max);
        logic  rsp;
        logic  exp_rv;
        logic  fire;
        req_t  r;
        @(negedge clk);
        stall          = s;
        branch_taken   = bt;
        new_pc         = npc;
        imem_req_ready = rdy;
        rsp            = rst && (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_data(pend[0].addr)
                             : {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        exp_rv = rst && !bt && ((pend.size() + mbuf.size()) < 2);
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, exp_pc);
        chk("inst_valid", inst_valid, mbuf.size() > 0);
        if (mbuf.size() > 0) begin
            chk("inst", inst, mem_data(mbuf[0]));
            chk("inst_pc", inst_pc, exp_lanes(mbuf[0]));
        end else begin
            chk("inst_nop", inst, {LANES{NOP_INST}});
        end

        fire = exp_rv && rdy;
        if (rsp) r = pend.pop_front();
        if (bt) begin
            exp_pc = npc & ~32'(4 * LANES - 1);
            foreach (pend[i]) pend[i].live = 1'b0;
            mbuf.delete();
        end else begin
            if (mbuf.size() > 0 && !s) void'(mbuf.pop_front());
            if (rsp && r.live) mbuf.push_back(r.addr);
            if (fire) begin
                pend.push_back('{addr: exp_pc, due: cyc + 1 + int'($urandom_range(lat_max)), live: 1'b1});
                exp_pc = exp_pc + 32'(4 * LANES);
            end
        end
        cyc++;
    endtask

    task automatic rand_cycle(input int p_stall, input int p_bt, input int p_rdy, input int lat_max);
        cycle(($urandom_range(99) < p_stall), ($urandom_range(99) < p_bt), $urandom(),
              ($urandom_range(99) < p_rdy), lat_max);
    endtask

    initial begin
        exp_pc = RST_PC;

        // Reset state while rst is held low.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, {LANES{NOP_INST}});
        chk("rst_inst_pc", inst_pc, exp_lanes(RST_PC));
        rst = 1'b1;

        // Streaming with short latencies and occasional stalls.
        for (int i = 0; i < 200; i++) rand_cycle(20, 0, 100, 2);

        // Hold stall with the buffer filling up.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1);

        // Redirect with requests outstanding, then random redirects.
        cycle(1'b0, 1'b1, 32'h0000_1234, 1'b1, 2);
        for (int i = 0; i < 150; i++) rand_cycle(20, 8, 90, 3);

        // Redirect held together with stall; final target must win.
        cycle(1'b1, 1'b1, 32'h0000_2008, 1'b1, 2);
        cycle(1'b1, 1'b1, 32'h0000_3010, 1'b1, 2);
        for (int i = 0; i < 20; i++) rand_cycle(10, 0, 100, 2);

        // Memory not ready for 5 cycles: buffer drains, request held.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b0, 2);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, '0, 1'b1, 2);

        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFF7, 1'b1, 1);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        rst            = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("async_rst_inst_valid", inst_valid, 1'b0);
        chk("async_rst_req_valid", imem_req_valid, 1'b0);
        chk("async_rst_inst_pc", inst_pc, exp_lanes(RST_PC));
        pend.delete();
        mbuf.delete();
        exp_pc = RST_PC;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Heavy random mix, including held redirects and back-to-back flushes.
        for (int i = 0; i < 600; i++) rand_cycle(30, 15, 70, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
